seq_shift_unit: RTL and testbench

//   Multi-cycle shift unit for the integer ALU datapath. It applies one single-bit shift per

---
 rtl/seq_shift_unit.sv | 117 +++++++++++
 tb/tb_seq_shift_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_unit
// Description : Multi-cycle shift unit. Performs one single-bit step per clock
//               (ASR, LSR, SHL or ROR) until the requested amount is consumed,
//               then presents the result with a one-cycle done pulse.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous reset, active-high
//               start - request, sampled when not shifting
//               op    - 00=ASR 01=LSR 10=SHL 11=ROR, sampled with start
//               a     - operand, sampled with start
//               amt   - shift amount, sampled with start
//               busy  - high while shifting
//               done  - one-cycle pulse when y holds the final result
//               y     - working/result register (direct flop output)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_OP_ASR = 2'b00;
  localparam logic [1:0] c_OP_LSR = 2'b01;
  localparam logic [1:0] c_OP_SHL = 2'b10;
  localparam logic [1:0] c_OP_ROR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] w_step;

  // One single-bit step of the latched operation applied to the working value.
  always_comb begin
    w_step = y_q;
    case (op_q)
      c_OP_ASR: w_step = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
      c_OP_LSR: w_step = {1'b0, y_q[WIDTH-1:1]};
      c_OP_SHL: w_step = {y_q[WIDTH-2:0], 1'b0};
      c_OP_ROR: w_step = {y_q[0], y_q[WIDTH-1:1]};
      default:  w_step = y_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new request directly so back-to-back ops have no gap.
        if (start) begin
          y_d     = a;
          cnt_d   = amt;
          op_d    = op;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // A zero amount still spends one cycle here, leaving y untouched.
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          y_d   = w_step;
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        // Unreachable encoding: recover to idle.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign y    = y_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_unit
// Description : Directed self-checking bench for seq_shift_unit (WIDTH=4,
//               AMT_W=3) with an exhaustive op x a x amt sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [3:0] a;
  logic [2:0] amt;
  logic       busy;
  logic       done;
  logic [3:0] y;

  int n_checks = 0;
  int n_errors = 0;

  seq_shift_unit #(.WIDTH(4), .AMT_W(3)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: iterate the single-bit step k times.
  function automatic logic [3:0] ref_model(input logic [1:0] o, input logic [3:0] v, input int k);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < k; i++) begin
      case (o)
        2'b00:   r = {r[3], r[3:1]};
        2'b01:   r = {1'b0, r[3:1]};
        2'b10:   r = {r[2:0], 1'b0};
        default: r = {r[0], r[3:1]};
      endcase
    end
    return r;
  endfunction

  // Present a request for one edge (driven at negedge).
  task automatic issue(input logic [1:0] o, input logic [3:0] av, input logic [2:0] k);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    amt   = k;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sample at negedges until done is seen; counts busy cycles. Bounded.
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) nbusy++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] av,
                        input logic [2:0] k, input logic [3:0] ey);
    int nb;
    bit seen;
    issue(o, av, k);
    wait_done(nb, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nb), (k == 3'd0) ? 32'd1 : 32'(k));
    chk({tag, "_y"}, 32'(y), 32'(ey));
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    chk({tag, "_y_hold"}, 32'(y), 32'(ey));
  endtask

  initial begin
    int  nb;
    bit  seen;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 4'h0;
    amt   = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_y", 32'(y), 32'd0);
    rst = 1'b0;

    // Directed vectors, expected results computed by hand.
    run_op("asr_1011_1", 2'b00, 4'b1011, 3'd1, 4'b1101);
    run_op("asr_1000_3", 2'b00, 4'b1000, 3'd3, 4'b1111);
    run_op("lsr_1000_5", 2'b01, 4'b1000, 3'd5, 4'b0000);
    run_op("shl_0111_2", 2'b10, 4'b0111, 3'd2, 4'b1100);
    run_op("ror_1001_1", 2'b11, 4'b1001, 3'd1, 4'b1100);
    run_op("ror_0110_4", 2'b11, 4'b0110, 3'd4, 4'b0110);
    run_op("asr_amt0",   2'b00, 4'b0101, 3'd0, 4'b0101);
    run_op("ror_0001_7", 2'b11, 4'b0001, 3'd7, 4'b0010);

    // Start during SHIFT is ignored.
    issue(2'b00, 4'b0100, 3'd3);
    @(negedge clk);
    start = 1'b1;
    a     = 4'b1111;
    op    = 2'b10;
    amt   = 3'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, seen);
    chk("ign_done_seen", 32'(seen), 32'd1);
    chk("ign_y", 32'(y), 32'b0000);
    // Back-to-back: start held in the done cycle loads immediately.
    start = 1'b1;
    op    = 2'b10;
    a     = 4'b0011;
    amt   = 3'd1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_no_gap", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(nb, seen);
    chk("b2b_done_seen", 32'(seen), 32'd1);
    chk("b2b_y", 32'(y), 32'b0110);
    @(negedge clk);

    // Reset during 2nd SHIFT cycle abandons the operation.
    issue(2'b01, 4'b1111, 3'd4);
    @(negedge clk);   // 1st SHIFT cycle
    @(negedge clk);   // 2nd SHIFT cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_y", 32'(y), 32'd0);
    @(negedge clk);
    chk("rstmid_stay_idle", 32'({busy, done}), 32'd0);
    run_op("after_rst", 2'b01, 4'b1111, 3'd2, 4'b0011);

    // Exhaustive sweep against the reference model.
    for (int o = 0; o < 4; o++) begin
      for (int v = 0; v < 16; v++) begin
        for (int k = 0; k < 8; k++) begin
          run_op($sformatf("sweep_op%0d_a%0h_k%0d", o, v, k), 2'(o), 4'(v), 3'(k),
                 ref_model(2'(o), 4'(v), k));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
